// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register engine: FSM encodings and command-byte layout.
package spi_reg_pkg;

  localparam int CMD_W    = 8;
  localparam int RW_BIT   = 7;
  localparam int ADDR_MSB = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // An address is decodable only if every bit above the decoded width is zero.
  function automatic logic addr_legal(input logic [ADDR_MSB:0] addr, input int addr_w);
    return (addr >> addr_w) == '0;
  endfunction

endpackage

// File: rtl/spi_edge_det.sv
// Registers the synchronized SCLK and chip select and flags their edges.
// Edge pulses are combinational against the registered copy; state holds while ena is low.
module spi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic spi_clk,
  input  logic spi_cs_n,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic clk_q;
  logic cs_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_q <= 1'b0;
      cs_q  <= 1'b1;
    end else if (ena) begin
      clk_q <= spi_clk;
      cs_q  <= spi_cs_n;
    end
  end

  assign sclk_rise = spi_clk & ~clk_q;
  assign sclk_fall = ~spi_clk & clk_q;
  assign cs_fall   = ~spi_cs_n & cs_q;
  assign cs_rise   = spi_cs_n & ~cs_q;

endmodule

// File: rtl/spi_reg_engine.sv
// SPI mode-0 target: 8-bit command + WIDTH-bit data frames onto a config/status register map.
// Read data is snapshotted at command decode; writes commit one clk after the last data rise.
module spi_reg_engine
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = $clog2(2 * NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      spi_cs_n,
  input  logic                      spi_clk,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic [NUM_REGS*WIDTH-1:0] config_regs,
  input  logic [NUM_REGS*WIDTH-1:0] status_regs,
  output logic                      wr_strobe,
  output logic [ADDR_W-1:0]         wr_addr
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic              sclk_rise;
  logic              sclk_fall;
  logic              cs_fall;
  logic              cs_rise_unused;

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WIDTH-2:0]  rx_sr;
  logic [WIDTH-1:0]  tx_sr;
  logic [ADDR_MSB:0] addr_q;
  logic              rw_q;
  logic              ok_q;
  logic [WIDTH-1:0]  cfg [NUM_REGS];

  logic [WIDTH-1:0]  shift_word;
  logic [CMD_W-1:0]  cmd_word;
  logic [ADDR_MSB:0] cmd_addr;
  logic              cmd_ok;
  logic [WIDTH-1:0]  rd_data;
  logic              wr_hit;

  spi_edge_det u_edge_det (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .spi_clk   (spi_clk),
    .spi_cs_n  (spi_cs_n),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise_unused)
  );

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cfg_out
    assign config_regs[i*WIDTH +: WIDTH] = cfg[i];
  end

  // The bit being sampled this cycle completes the word in flight.
  assign shift_word = {rx_sr, spi_mosi};
  assign cmd_word   = shift_word[CMD_W-1:0];
  assign cmd_addr   = cmd_word[ADDR_MSB:0];
  assign cmd_ok     = addr_legal(cmd_addr, ADDR_W);
  assign wr_hit     = rw_q && ok_q && (addr_q < 7'(NUM_REGS));

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == 7'(i))
        rd_data = cfg[i];
      if (cmd_addr == 7'(NUM_REGS + i))
        rd_data = status_regs[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      ok_q      <= 1'b0;
      spi_miso  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < NUM_REGS; i++)
        cfg[i] <= '0;
    end else if (ena) begin
      wr_strobe <= 1'b0;
      // Deselect wins over everything; SCLK edges in a deselected cycle never count.
      if (spi_cs_n) begin
        state    <= ST_IDLE;
        spi_miso <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cs_fall) begin
              state   <= ST_CMD;
              bit_cnt <= '0;
            end
          end

          ST_CMD: begin
            if (sclk_rise) begin
              rx_sr <= shift_word[WIDTH-2:0];
              if (bit_cnt == CNT_W'(CMD_W - 1)) begin
                addr_q  <= cmd_addr;
                rw_q    <= cmd_word[RW_BIT];
                ok_q    <= cmd_ok;
                tx_sr   <= cmd_ok ? rd_data : '0;
                bit_cnt <= '0;
                state   <= ST_DATA;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end

          ST_DATA: begin
            if (sclk_rise) begin
              rx_sr <= shift_word[WIDTH-2:0];
              if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                if (wr_hit) begin
                  for (int i = 0; i < NUM_REGS; i++)
                    if (addr_q == 7'(i))
                      cfg[i] <= shift_word;
                  wr_strobe <= 1'b1;
                  wr_addr   <= addr_q[ADDR_W-1:0];
                end
                spi_miso <= 1'b0;
                state    <= ST_DONE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (sclk_fall) begin
              spi_miso <= tx_sr[WIDTH-1];
              tx_sr    <= {tx_sr[WIDTH-2:0], 1'b0};
            end
          end

          default: begin
            spi_miso <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
